// File: rtl/seq_detector.sv
`default_nettype none
// seq_detector: Moore detector for a run-time programmable N-bit serial pattern,
// with overlap control, enable qualifier and a saturating match counter.
module seq_detector #(
  parameter int N  = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          r,
  input  logic          en,
  input  logic          clr,
  input  logic          x,
  input  logic [N-1:0]  pattern,
  input  logic          overlap,
  output logic          z,
  output logic [CW-1:0] count,
  output logic          sat
);

  localparam int              FW       = $clog2(N + 1);
  localparam logic [FW-1:0]   FILL_MAX = FW'(N);
  localparam logic [CW-1:0]   CNT_MAX  = {CW{1'b1}};

  logic [N-1:0]  hist_q,  hist_d;
  logic [FW-1:0] fill_q,  fill_d;
  logic [CW-1:0] count_q, count_d;
  logic          sat_q,   sat_d;
  logic          z_q,     z_d;

  logic [N-1:0]  hist_nx;
  logic [FW-1:0] fill_nx;
  logic          match;

  always_comb begin
    hist_nx = {hist_q[N-2:0], x};
    fill_nx = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + FW'(1);
    match   = (fill_nx == FILL_MAX) && (hist_nx == pattern);
  end

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    count_d = count_q;
    sat_d   = sat_q;
    z_d     = 1'b0;
    if (clr) begin
      hist_d  = '0;
      fill_d  = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end else if (en) begin
      hist_d = hist_nx;
      if (match) begin
        z_d = 1'b1;
        if (count_q != CNT_MAX) count_d = count_q + CW'(1);
        else                    sat_d   = 1'b1;
        // Without overlap the completing bits must not seed the next match.
        fill_d = overlap ? FILL_MAX : '0;
      end else begin
        fill_d = fill_nx;
      end
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      hist_q  <= '0;
      fill_q  <= '0;
      count_q <= '0;
      sat_q   <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      count_q <= count_d;
      sat_q   <= sat_d;
      z_q     <= z_d;
    end
  end

  assign z     = z_q;
  assign count = count_q;
  assign sat   = sat_q;

endmodule
`default_nettype wire

// File: doc/seq_detector.md
# seq_detector

Parametrised Moore sequence detector for serial control streams. It watches a single-bit input and flags every occurrence of a run-time programmable N-bit pattern. It supports overlapping and non-overlapping matches, an enable qualifier and a saturating match counter. It generalises the team's fixed 2-flip-flop detectors, and downstream control logic uses it wherever a serial bit pattern must be recognised and counted.

## Interface
- N, default 4: pattern length in bits, N ≥ 2.
- CW, default 8: match counter width in bits, CW ≥ 1.

Ports:
- clk  in  1: clock; all state updates on the rising edge.
- r  in  1: reset, asynchronous, active-low. r=0 clears all state immediately.
- en  in  1: bit-valid qualifier. x is sampled only on edges where en=1.
- clr  in  1: synchronous clear of history, counter, sat and z. Has priority over en.
- x  in  1: serial data bit.
- pattern  in  N: target pattern. pattern[N-1] is the first bit received, pattern[0] the last. Compared combinationally, so changes take effect on the next sampled bit.
- overlap  in  1: 1 = overlapping matches allowed; 0 = history restarts after each match.
- z  out  1: registered match pulse. High for exactly the one cycle after the edge that sampled the completing bit.
- count  out  CW: number of matches, saturating at 2^CW-1.
- sat  out  1: sticky flag. Set when a match occurs while count is already 2^CW-1.

## Operation
- State registers:
  - hist[N-1:0], the shift history.
  - fill, 0..N, the number of valid bits in hist.
  - count, sat, z.
- Reset (r=0, asynchronous): hist=0, fill=0, count=0, sat=0, z=0. Outputs are 0 while r=0. The first sampling edge is the first rising edge with r=1.
- Per rising edge, in priority order:
  1. clr=1: hist, fill, count, sat and z are all set to 0.
  2. en=0: hist, fill, count and sat hold; z is set to 0.
  3. en=1: compute the next values.
     - hist_n = {hist[N-2:0], x}
     - fill_n = min(fill+1, N)
     - match = (fill_n == N) && (hist_n == pattern)
- On match:
  - z<=1.
  - If count < 2^CW-1, count<=count+1; otherwise count holds and sat<=1.
  - hist<=hist_n.
  - If overlap=1, fill<=N. If overlap=0, fill<=0 (the completing bits cannot start the next match).
- No match: z<=0, hist<=hist_n, fill<=fill_n.
- Changing overlap mid-stream affects only the decision on the next match.
- fill never exceeds N, so no wrap-around is possible. count never wraps.
- Width rule: fill needs ceil(log2(N+1)) bits. The comparison is exactly N bits wide.

## Timing
- Latency: z rises one clock after the edge that sampled the last pattern bit, and is a single-cycle pulse.
- With overlap=1 and a self-overlapping pattern (e.g. all ones), z may stay high on consecutive cycles, once per match.
- count and sat update on the same edge as z.
- r asserted mid-stream clears everything asynchronously. A pattern partially received before reset is never completed.
- en and clr must be synchronous to clk. x is ignored on cycles where en=0.

## Test plan
Default parameters N=4, CW=8, pattern=4'b1011 unless stated.
- Async reset: drive r=0 between clock edges → z=0, count=0, sat=0 immediately with no clock edge. Release r, send no bits → all stay 0.
- Overlap: overlap=1, en=1, x stream 1,0,1,1,0,1,1 → z pulses the cycle after bit 4 and the cycle after bit 7; final count=2, sat=0.
- Non-overlap: overlap=0, same stream → z pulses only after bit 4, because fill restarts and bits 5–7 are only 3 bits; count=1.
- Enable gaps: same stream as the overlap test with en=0 inserted for 2 cycles between every bit and x toggled randomly during the gaps → same two matches, count=2. z is only high in the cycle after an en=1 edge.
- Saturation: CW=3, pattern=4'b1111, overlap=1, x=1 for 11 sampled bits → matches at bits 4..11, z high for 8 consecutive cycles. count stops at 7 after bit 10; bit 11 sets sat=1 with count=7. A following clr=1 with en=1 → count=0, sat=0, z=0, and that bit is not sampled.
- Reset mid-pattern: send 1,0,1, then pulse r=0, then send 1 → no match, z=0, count=0. Then send 0,1,1 → match after that third bit, count=1.
